// File: rtl/dlyprog_sync.sv
// Run-time programmable delay line: delays I by 1..DEPTH enabled clock cycles, with hold, flush and fill-valid.
// Optional macro DLYPROG_BYPASS_EN: SEL=0 routes I straight to Z with VLD forced high.
module dlyprog_sync #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8,
   localparam int SELW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] I,
   input  logic             EN,
   input  logic             FLUSH,
   input  logic [SELW-1:0]  SEL,
   output logic [WIDTH-1:0] Z,
   output logic             VLD
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);
   localparam logic [SELW-1:0] ONE_S   = SELW'(1);

   logic [WIDTH-1:0] r_stage [DEPTH];
   logic [SELW-1:0]  r_fill_cnt;

   logic [SELW-1:0]  w_sel_eff;
   logic [SELW-1:0]  w_tap;
   logic [WIDTH-1:0] w_tap_data;
   logic             w_tap_vld;

   // Shift register: stage 0 captures I, every later stage takes its predecessor.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] w_src;
         if (gi == 0) begin : g_head
            assign w_src = I;
         end else begin : g_body
            assign w_src = r_stage[gi-1];
         end

         always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
               r_stage[gi] <= '0;
            end else if (FLUSH) begin
               r_stage[gi] <= '0;
            end else if (EN) begin
               r_stage[gi] <= w_src;
            end
         end
      end
   endgenerate

   // Fill counter saturates so VLD can never fall back through wrap-around.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_fill_cnt <= '0;
      end else if (FLUSH) begin
         r_fill_cnt <= '0;
      end else if (EN && (r_fill_cnt != DEPTH_S)) begin
         r_fill_cnt <= r_fill_cnt + ONE_S;
      end
   end

   // Ternaries keep an unknown SEL visible as X on the outputs only.
   assign w_sel_eff  = (SEL == '0) ? ONE_S : ((SEL > DEPTH_S) ? DEPTH_S : SEL);
   assign w_tap      = w_sel_eff - ONE_S;
   assign w_tap_data = r_stage[w_tap[IDXW-1:0]];
   assign w_tap_vld  = (r_fill_cnt >= w_sel_eff);

`ifdef DLYPROG_BYPASS_EN
   assign Z   = (SEL == '0) ? I    : w_tap_data;
   assign VLD = (SEL == '0) ? 1'b1 : w_tap_vld;
`else
   assign Z   = w_tap_data;
   assign VLD = w_tap_vld;
`endif

endmodule

// File: tb/tb_dlyprog_sync.sv
// Directed self-checking bench for dlyprog_sync (WIDTH=8, DEPTH=8).
module tb_dlyprog_sync;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int SELW  = $clog2(DEPTH + 1);

   logic             CLK;
   logic             RN;
   logic [WIDTH-1:0] I;
   logic             EN;
   logic             FLUSH;
   logic [SELW-1:0]  SEL;
   logic [WIDTH-1:0] Z;
   logic             VLD;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   dlyprog_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RN(RN), .I(I), .EN(EN), .FLUSH(FLUSH),
      .SEL(SEL), .Z(Z), .VLD(VLD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
      $display("cyc %0d: RN=%0b EN=%0b FLUSH=%0b SEL=%0d I=%02h -> Z=%02h VLD=%0b",
               cyc, RN, EN, FLUSH, SEL, I, Z, VLD);
   endtask

   task automatic test_reset();
      RN = 1'b0; I = 8'hFF; EN = 1'b1; FLUSH = 1'b0; SEL = 4'd3;
      #2;
      n_checks++;
      if ({VLD, Z} !== 9'h000) begin
         n_fail++;
         $display("FAIL reset_t0: got VLD=%0b Z=%02h want VLD=0 Z=00", VLD, Z);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if ({VLD, Z} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got VLD=%0b Z=%02h want VLD=0 Z=00", k, VLD, Z);
         end
      end
      RN = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] ez;
      logic       ev;
      SEL = 4'd3; EN = 1'b1; FLUSH = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         I = 8'(k);
         step();
         ez = (k >= 3) ? 8'(k - 2) : 8'h00;
         ev = (k >= 3);
         n_checks++;
         if (Z !== ez || VLD !== ev) begin
            n_fail++;
            $display("FAIL basic[%0d]: got VLD=%0b Z=%02h want VLD=%0b Z=%02h", k, VLD, Z, ev, ez);
         end
      end
   endtask

   task automatic test_hold();
      EN = 1'b0; I = 8'h77;
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if (Z !== 8'h08 || VLD !== 1'b1) begin
            n_fail++;
            $display("FAIL hold[%0d]: got VLD=%0b Z=%02h want VLD=1 Z=08", k, VLD, Z);
         end
      end
      EN = 1'b1;
      for (int k = 11; k <= 13; k++) begin
         I = 8'(k);
         step();
         n_checks++;
         if (Z !== 8'(k - 2) || VLD !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_resume[%0d]: got VLD=%0b Z=%02h want VLD=1 Z=%02h", k, VLD, Z, 8'(k - 2));
         end
      end
   endtask

   task automatic test_tap_change();
      logic [7:0] ez;
      logic       ev;
      SEL = 4'd2;
      #1;
      n_checks++;
      if (Z !== 8'h0C || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL tap_sel2: got VLD=%0b Z=%02h want VLD=1 Z=0c", VLD, Z);
      end
      I = 8'h0E;
      step();
      n_checks++;
      if (Z !== 8'h0D || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL tap_sel2_step: got VLD=%0b Z=%02h want VLD=1 Z=0d", VLD, Z);
      end
      SEL = 4'd6;
      #1;
      n_checks++;
      if (Z !== 8'h09 || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL tap_sel6: got VLD=%0b Z=%02h want VLD=1 Z=09", VLD, Z);
      end
      I = 8'h0F;
      step();
      n_checks++;
      if (Z !== 8'h0A || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL tap_sel6_step: got VLD=%0b Z=%02h want VLD=1 Z=0a", VLD, Z);
      end
      FLUSH = 1'b1; I = 8'hA5;
      step();
      FLUSH = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         I = 8'(8'h20 + k);
         step();
         ez = (k >= 6) ? 8'h21 : 8'h00;
         ev = (k >= 6);
         n_checks++;
         if (Z !== ez || VLD !== ev) begin
            n_fail++;
            $display("FAIL tap_refill[%0d]: got VLD=%0b Z=%02h want VLD=%0b Z=%02h", k, VLD, Z, ev, ez);
         end
      end
   endtask

   task automatic test_flush_clamp();
      logic [7:0] ez;
      logic       ev;
      FLUSH = 1'b1; EN = 1'b1; I = 8'hA5;
      step();
      n_checks++;
      if (Z !== 8'h00 || VLD !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: got VLD=%0b Z=%02h want VLD=0 Z=00", VLD, Z);
      end
      FLUSH = 1'b0; SEL = 4'd9;
      for (int k = 1; k <= 9; k++) begin
         I = 8'(8'h30 + k);
         step();
         ez = (k >= 8) ? 8'(8'h30 + k - 7) : 8'h00;
         ev = (k >= 8);
         n_checks++;
         if (Z !== ez || VLD !== ev) begin
            n_fail++;
            $display("FAIL clamp_sel9[%0d]: got VLD=%0b Z=%02h want VLD=%0b Z=%02h", k, VLD, Z, ev, ez);
         end
      end
      SEL = 4'd8;
      #1;
      n_checks++;
      if (Z !== 8'h32 || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL clamp_sel8: got VLD=%0b Z=%02h want VLD=1 Z=32", VLD, Z);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] ez;
      logic       ev;
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0; SEL = 4'd8;
      for (int k = 1; k <= 20; k++) begin
         I = 8'(8'h50 + k);
         step();
         ez = (k >= 8) ? 8'(8'h50 + k - 7) : 8'h00;
         ev = (k >= 8);
         n_checks++;
         if (Z !== ez || VLD !== ev) begin
            n_fail++;
            $display("FAIL saturate[%0d]: got VLD=%0b Z=%02h want VLD=%0b Z=%02h", k, VLD, Z, ev, ez);
         end
      end
   endtask

   task automatic test_sel0();
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0; SEL = 4'd0;
`ifdef DLYPROG_BYPASS_EN
      I = 8'h6C;
      #1;
      n_checks++;
      if (Z !== 8'h6C || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass: got VLD=%0b Z=%02h want VLD=1 Z=6c", VLD, Z);
      end
      RN = 1'b0; I = 8'h93;
      #1;
      n_checks++;
      if (Z !== 8'h93 || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_reset: got VLD=%0b Z=%02h want VLD=1 Z=93", VLD, Z);
      end
      step();
      RN = 1'b1;
`else
      #1;
      n_checks++;
      if (Z !== 8'h00 || VLD !== 1'b0) begin
         n_fail++;
         $display("FAIL sel0_empty: got VLD=%0b Z=%02h want VLD=0 Z=00", VLD, Z);
      end
      I = 8'h40;
      step();
      n_checks++;
      if (Z !== 8'h40 || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL sel0_first: got VLD=%0b Z=%02h want VLD=1 Z=40", VLD, Z);
      end
      I = 8'h41;
      step();
      n_checks++;
      if (Z !== 8'h41 || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL sel0_second: got VLD=%0b Z=%02h want VLD=1 Z=41", VLD, Z);
      end
`endif
   endtask

   task automatic test_async_reset();
      SEL = 4'd3; EN = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         I = 8'(8'h70 + k);
         step();
      end
      #2;
      RN = 1'b0;
      #1;
      n_checks++;
      if (Z !== 8'h00 || VLD !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got VLD=%0b Z=%02h want VLD=0 Z=00", VLD, Z);
      end
      step();
      n_checks++;
      if (Z !== 8'h00 || VLD !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_hold: got VLD=%0b Z=%02h want VLD=0 Z=00", VLD, Z);
      end
      RN = 1'b1; SEL = 4'd2;
      I = 8'h81;
      step();
      n_checks++;
      if (Z !== 8'h00 || VLD !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_1: got VLD=%0b Z=%02h want VLD=0 Z=00", VLD, Z);
      end
      I = 8'h82;
      step();
      n_checks++;
      if (Z !== 8'h81 || VLD !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_2: got VLD=%0b Z=%02h want VLD=1 Z=81", VLD, Z);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_tap_change();
      test_flush_clamp();
      test_saturation();
      test_sel0();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
